// File: rtl/eeprom_rw_ctrl.sv
// EEPROM self-test sequencer: writes addr^PATTERN to BYTE_NUM addresses (NACK retries), then reads back and compares.
// One transfer outstanding at a time; exec only after the previous done; FINISH is terminal until reset.
module eeprom_rw_ctrl #(
  parameter int unsigned BYTE_NUM  = 256,
  parameter int unsigned START_DLY = 1000,
  parameter int unsigned WR_GAP    = 5000,
  parameter logic [7:0]  PATTERN   = 8'hA5,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  output logic        bit_ctrl,
  output logic        rw_done,
  output logic        rw_pass,
  output logic [8:0]  err_cnt
);

  localparam int unsigned DLY_N   = (START_DLY == 0) ? 1 : START_DLY;
  localparam int unsigned GAP_N   = (WR_GAP == 0) ? 1 : WR_GAP;
  localparam int unsigned TMR_MAX = (DLY_N > GAP_N) ? DLY_N : GAP_N;
  localparam int          TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int          RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] DLY_LAST  = TW'(DLY_N - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_N - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    LAST_ADDR = 8'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    ST_DLY,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [7:0]      addr_cnt, addr_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic            wr_ok, wr_ok_nxt;
  logic            fatal, fatal_nxt;
  logic [8:0]      err_nxt;
  logic            rd_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DLY;
      tmr      <= '0;
      addr_cnt <= '0;
      retry    <= '0;
      wr_ok    <= 1'b0;
      fatal    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      addr_cnt <= addr_nxt;
      retry    <= retry_nxt;
      wr_ok    <= wr_ok_nxt;
      fatal    <= fatal_nxt;
      err_cnt  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = '0;
    addr_nxt  = addr_cnt;
    retry_nxt = retry;
    wr_ok_nxt = wr_ok;
    fatal_nxt = fatal;
    err_nxt   = err_cnt;
    rd_bad    = i2c_ack || (i2c_data_r != (addr_cnt ^ PATTERN));

    case (state)
      ST_DLY: begin
        if (tmr == DLY_LAST) begin
          addr_nxt  = '0;
          state_nxt = ST_WR_REQ;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      ST_WR_REQ: state_nxt = ST_WR_WAIT;

      ST_WR_WAIT: begin
        if (i2c_done) begin
          if (!i2c_ack) begin
            retry_nxt = '0;
            wr_ok_nxt = 1'b1;
            state_nxt = ST_WR_GAP;
          end else if (retry < RETRY_MAX) begin
            retry_nxt = retry + 1'b1;
            wr_ok_nxt = 1'b0;
            state_nxt = ST_WR_GAP;
          end else begin
            fatal_nxt = 1'b1;
            state_nxt = ST_FINISH;
          end
        end
      end

      // The EEPROM is busy internally after every write attempt, ACKed or not.
      ST_WR_GAP: begin
        if (tmr == GAP_LAST) begin
          if (wr_ok && (addr_cnt == LAST_ADDR)) begin
            addr_nxt  = '0;
            state_nxt = ST_RD_REQ;
          end else begin
            if (wr_ok) addr_nxt = addr_cnt + 1'b1;
            state_nxt = ST_WR_REQ;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      ST_RD_REQ: state_nxt = ST_RD_WAIT;

      ST_RD_WAIT: begin
        if (i2c_done) begin
          if (rd_bad && (err_cnt != 9'h1FF)) err_nxt = err_cnt + 1'b1;
          if (addr_cnt == LAST_ADDR) begin
            state_nxt = ST_FINISH;
          end else begin
            addr_nxt  = addr_cnt + 1'b1;
            state_nxt = ST_RD_REQ;
          end
        end
      end

      ST_FINISH: state_nxt = ST_FINISH;

      default: state_nxt = ST_DLY;
    endcase
  end

  // Request fields are loaded on entry to a request state and then held, so they
  // stay stable across the whole transfer even though addr_cnt advances on done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= '0;
      i2c_data_w <= '0;
    end else if (state_nxt == ST_WR_REQ) begin
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= {8'h00, addr_nxt};
      i2c_data_w <= addr_nxt ^ PATTERN;
    end else if (state_nxt == ST_RD_REQ) begin
      i2c_rh_wl  <= 1'b1;
      i2c_addr   <= {8'h00, addr_nxt};
    end
  end

  assign i2c_exec = (state == ST_WR_REQ) || (state == ST_RD_REQ);
  assign bit_ctrl = 1'b1;
  assign rw_done  = (state == ST_FINISH);
  assign rw_pass  = rw_done && (err_cnt == 9'd0) && !fatal;

endmodule

// File: tb/tb_eeprom_rw_ctrl.sv
// Bench for eeprom_rw_ctrl: a memory-backed EEPROM responder with NACK/corruption injection
// and a per-scenario expectation derived from the configured fault plan.
module tb_eeprom_rw_ctrl;
  localparam int         BN  = 4;
  localparam int         SD  = 20;
  localparam int         WG  = 30;
  localparam int         MR  = 3;
  localparam logic [7:0] PAT = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        i2c_exec, i2c_rh_wl, bit_ctrl, rw_done, rw_pass;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [8:0]  err_cnt;

  eeprom_rw_ctrl #(
    .BYTE_NUM(BN), .START_DLY(SD), .WR_GAP(WG), .PATTERN(PAT), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .i2c_data_r(i2c_data_r), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
    .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .bit_ctrl(bit_ctrl),
    .rw_done(rw_done), .rw_pass(rw_pass), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  int  nack_plan [256];
  int  wr_att [256];
  bit  corrupt [256];
  bit  rd_nack [256];

  bit  spur_en, hold_en, held, force_done, busy, wdone_vld;
  int  exec_cnt, wr_cnt, rd_cnt, viol, stab_bad, gap_bad;
  int  first_exec_cyc, rel_cyc, last_wdone, lat, held_addr;
  logic        cur_rh;
  logic [15:0] cur_addr;
  logic [7:0]  cur_data;
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_addr_q[$];

  // EEPROM responder and protocol monitor; everything happens on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      i2c_done = 1'b0;
      if (force_done && held) begin
        i2c_done   = 1'b1;
        i2c_ack    = 1'b0;
        i2c_data_r = mem[held_addr];
        held       = 1'b0;
        force_done = 1'b0;
      end else if (i2c_exec) begin
        if (busy) viol++;
        if (exec_cnt == 0) first_exec_cyc = cyc;
        exec_cnt++;
        if (wdone_vld) begin
          if (cyc - last_wdone != WG + 1) gap_bad++;
          wdone_vld = 1'b0;
        end
        cur_rh   = i2c_rh_wl;
        cur_addr = i2c_addr;
        cur_data = i2c_data_w;
        if (i2c_rh_wl) begin
          rd_cnt++;
          rd_addr_q.push_back(int'(i2c_addr));
        end else begin
          wr_cnt++;
          wr_addr_q.push_back(int'(i2c_addr));
          wr_data_q.push_back(int'(i2c_data_w));
        end
        if (hold_en && i2c_rh_wl && i2c_addr == 16'd1) begin
          held      = 1'b1;
          held_addr = 1;
          hold_en   = 1'b0;
        end else begin
          busy = 1'b1;
          lat  = int'($urandom_range(1, 6));
        end
      end else if (busy) begin
        if (i2c_addr !== cur_addr || i2c_rh_wl !== cur_rh || i2c_data_w !== cur_data) stab_bad++;
        lat--;
        if (lat == 0) begin
          int a;
          a = int'(cur_addr[7:0]);
          busy     = 1'b0;
          i2c_done = 1'b1;
          if (!cur_rh) begin
            wr_att[a]++;
            if (wr_att[a] <= nack_plan[a]) i2c_ack = 1'b1;
            else begin
              i2c_ack = 1'b0;
              mem[a]  = cur_data;
            end
            wdone_vld  = 1'b1;
            last_wdone = cyc;
          end else begin
            i2c_ack    = rd_nack[a];
            i2c_data_r = corrupt[a] ? 8'h00 : mem[a];
          end
        end
      end else if (spur_en && wdone_vld && (cyc - last_wdone == 5)) begin
        i2c_done   = 1'b1;
        i2c_ack    = 1'($urandom_range(0, 1));
        i2c_data_r = 8'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00; nack_plan[i] = 0; wr_att[i] = 0; corrupt[i] = 1'b0; rd_nack[i] = 1'b0;
    end
    spur_en = 1'b0; hold_en = 1'b0; busy = 1'b0; wdone_vld = 1'b0;
    exec_cnt = 0; wr_cnt = 0; rd_cnt = 0; viol = 0; stab_bad = 0; gap_bad = 0;
    first_exec_cyc = 0;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk); #2;
    check({tag, "_rst_out"}, 64'({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w}), 64'(0));
    check({tag, "_rst_stat"}, 64'({rw_done, rw_pass, err_cnt, bit_ctrl}), 64'(12'h001));
    clear_model();
    @(negedge clk); #2;
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (rw_done !== 1'b1 && n < 5000) begin
      @(negedge clk); #2;
      n++;
    end
    check({tag, "_done_seen"}, 64'(rw_done), 64'(1));
    repeat (40) @(negedge clk);
    #2;
  endtask

  // Expected transfer sequence from the fault plan: each address is written until
  // ACKed, giving up after MR retries; reads happen only if every write succeeded.
  task automatic check_run(input string tag);
    int wa[$];
    int ee, er;
    bit fat;
    ee = 0; fat = 1'b0;
    for (int a = 0; a < BN && !fat; a++) begin
      int n;
      n = (nack_plan[a] > MR) ? MR + 1 : nack_plan[a] + 1;
      for (int k = 0; k < n; k++) wa.push_back(a);
      if (nack_plan[a] > MR) fat = 1'b1;
    end
    er = fat ? 0 : BN;
    if (!fat) for (int a = 0; a < BN; a++) if (corrupt[a] || rd_nack[a]) ee++;

    check({tag, "_first_exec_dly"}, 64'(first_exec_cyc - rel_cyc), 64'(SD));
    check({tag, "_rw_done"}, 64'(rw_done), 64'(1));
    check({tag, "_rw_pass"}, 64'(rw_pass), 64'(!fat && ee == 0));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(ee));
    check({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(wa.size()));
    check({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(er));
    check({tag, "_exec_total"}, 64'(exec_cnt), 64'(wa.size() + er));
    for (int i = 0; i < wa.size() && i < wr_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(wa[i]));
      check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(8'(wa[i]) ^ PAT));
    end
    for (int i = 0; i < er && i < rd_addr_q.size(); i++)
      check({tag, "_rd_addr"}, 64'(rd_addr_q[i]), 64'(i));
    check({tag, "_overlap"}, 64'(viol), 64'(0));
    check({tag, "_stable"}, 64'(stab_bad), 64'(0));
    check({tag, "_gap"}, 64'(gap_bad), 64'(0));
  endtask

  initial begin
    held = 1'b0;
    force_done = 1'b0;
    clear_model();

    // Ideal EEPROM
    reset_dut("ideal");
    run_to_done("ideal");
    check_run("ideal");
    for (int i = 0; i < BN; i++) check("ideal_mem", 64'(mem[i]), 64'(8'(i) ^ PAT));

    // Read of address 2 returns zero
    reset_dut("corrupt");
    corrupt[2] = 1'b1;
    run_to_done("corrupt");
    check_run("corrupt");

    // Two NACKs on address 1, then ACK
    reset_dut("nack1");
    nack_plan[1] = 2;
    run_to_done("nack1");
    check_run("nack1");

    // EEPROM never ACKs a write
    reset_dut("allnack");
    for (int i = 0; i < BN; i++) nack_plan[i] = 1000;
    run_to_done("allnack");
    check_run("allnack");

    // Spurious done pulses inside the write gap
    reset_dut("spur");
    spur_en = 1'b1;
    run_to_done("spur");
    check_run("spur");

    // Reset while a read is outstanding; its done arrives late, during the start delay
    reset_dut("rdhold");
    hold_en = 1'b1;
    begin
      int n;
      n = 0;
      while (!held && n < 5000) begin
        @(negedge clk); #2;
        n++;
      end
    end
    check("rdhold_held", 64'(held), 64'(1));
    repeat (3) @(negedge clk);
    reset_dut("rdabort");
    repeat (2) @(negedge clk);
    #2;
    force_done = 1'b1;
    run_to_done("rdabort");
    check("rdabort_late_done_sent", 64'(held), 64'(0));
    check_run("rdabort");

    // Randomized fault plans
    for (int it = 0; it < 6; it++) begin
      reset_dut("rand");
      for (int a = 0; a < BN; a++) begin
        nack_plan[a] = ($urandom_range(0, 9) == 0) ? MR + 1 : int'($urandom_range(0, 2));
        corrupt[a]   = ($urandom_range(0, 3) == 0);
        rd_nack[a]   = ($urandom_range(0, 5) == 0);
      end
      spur_en = 1'($urandom_range(0, 1));
      run_to_done("rand");
      check_run("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeprom_rw_ctrl.md
EEPROM_RW_CTRL -- requirements
Module: eeprom_rw_ctrl

Interface
REQ-001 SHALL have parameter BYTE_NUM, default 256, number of bytes written then read back (1..256).
REQ-002 SHALL have parameter START_DLY, default 1000, clk cycles from reset release to the first transfer.
REQ-003 SHALL have parameter WR_GAP, default 5000, clk cycles of EEPROM write-cycle wait after each write (5 ms at 1 MHz clk).
REQ-004 SHALL have parameter PATTERN, default 8'hA5, XOR mask applied to write data.
REQ-005 SHALL have parameter MAX_RETRY, default 3, number of NACK retries allowed per write byte.
REQ-006 clk  input  1  I2C driver clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 i2c_done  input  1  single-cycle pulse from the driver when a transfer ends.
REQ-009 i2c_ack  input  1  driver ack status, valid with i2c_done: 0 = ACK, 1 = NACK.
REQ-010 i2c_data_r  input  8  read byte from the driver, valid with i2c_done.
REQ-011 i2c_exec  output  1  single-cycle transfer request to the driver.
REQ-012 i2c_rh_wl  output  1  1 = read, 0 = write.
REQ-013 i2c_addr  output  16  EEPROM byte address.
REQ-014 i2c_data_w  output  8  write byte.
REQ-015 bit_ctrl  output  1  constant 1, meaning 16-bit word address.
REQ-016 rw_done  output  1  high when the test finishes; held until reset.
REQ-017 rw_pass  output  1  valid while rw_done: 1 = all bytes matched with no fatal NACK.
REQ-018 err_cnt  output  9  mismatch count, saturating at 511.

Function
REQ-019 SHALL implement the states DLY, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT and FINISH.
REQ-020 DLY SHALL count START_DLY cycles, then go to WR_REQ with addr_cnt = 0.
REQ-021 WR_REQ SHALL pulse i2c_exec for one cycle with i2c_rh_wl = 0, i2c_addr = {8'h00, addr_cnt}, i2c_data_w = addr_cnt ^ PATTERN, then go to WR_WAIT.
REQ-022 i2c_addr, i2c_data_w and i2c_rh_wl SHALL be stable from the exec cycle until the cycle after i2c_done.
REQ-023 In WR_WAIT, on i2c_done with i2c_ack = 0, SHALL clear the retry counter and go to WR_GAP.
REQ-024 In WR_WAIT, on i2c_done with i2c_ack = 1 and retry < MAX_RETRY, SHALL increment retry and go to WR_GAP, then reissue the same address and data.
REQ-025 In WR_WAIT, on i2c_done with i2c_ack = 1 and retry = MAX_RETRY, SHALL set the fatal flag and go to FINISH.
REQ-026 WR_GAP SHALL wait WR_GAP cycles.
REQ-027 After WR_GAP, if the previous write was ACKed and addr_cnt = BYTE_NUM-1, SHALL clear addr_cnt and go to RD_REQ.
REQ-028 After WR_GAP otherwise, SHALL go to WR_REQ, with addr_cnt incremented only if the previous write was ACKed.
REQ-029 RD_REQ SHALL pulse i2c_exec for one cycle with i2c_rh_wl = 1 and i2c_addr = {8'h00, addr_cnt}, then go to RD_WAIT.
REQ-030 In RD_WAIT, on i2c_done, SHALL compare i2c_data_r with addr_cnt ^ PATTERN.
REQ-031 On a read mismatch, or on i2c_ack = 1 at read done, SHALL increment err_cnt, saturating at 511.
REQ-032 Reads SHALL NOT be retried.
REQ-033 After a read, if addr_cnt = BYTE_NUM-1, SHALL go to FINISH; otherwise SHALL increment addr_cnt and go to RD_REQ.
REQ-034 FINISH SHALL assert rw_done and set rw_pass = (err_cnt = 0) and not fatal.
REQ-035 FINISH SHALL be terminal: no further i2c_exec until reset.
REQ-036 i2c_done outside WR_WAIT and RD_WAIT SHALL be ignored.
REQ-037 SHALL never issue a second i2c_exec before the i2c_done of the previous request.
REQ-038 addr_cnt SHALL be 8 bits and SHALL NOT wrap past BYTE_NUM-1.
REQ-039 With BYTE_NUM = 256, the last address SHALL be 0x00FF.

Reset
REQ-040 On rst_n low, SHALL asynchronously set state = DLY and clear all counters and flags.
REQ-041 Outputs at reset SHALL be: i2c_exec = 0, i2c_rh_wl = 0, i2c_addr = 0, i2c_data_w = 0, rw_done = 0, rw_pass = 0, err_cnt = 0; bit_ctrl = 1.
REQ-042 Reset during a transfer SHALL abandon it; a late i2c_done arriving in DLY SHALL be ignored.

Verification
REQ-043 Ideal EEPROM model (always ACK, memory-backed), BYTE_NUM = 4, PATTERN = 8'hA5 -> writes A5, A4, A7, A6 to 0x0000..0x0003; four reads follow; rw_done = 1, rw_pass = 1, err_cnt = 0.
REQ-044 Model returns 8'h00 on the read of address 2 -> err_cnt = 1, rw_pass = 0, all 4 reads still issued.
REQ-045 Model NACKs the first two write attempts of address 1 -> three writes to 0x0001 separated by WR_GAP; test passes.
REQ-046 Model always NACKs writes -> exactly MAX_RETRY+1 = 4 exec pulses, then rw_done = 1, rw_pass = 0, no reads.
REQ-047 rst_n pulsed low in RD_WAIT, then i2c_done arrives -> outputs return to reset values and the sequence restarts from DLY and address 0.
REQ-048 Spurious i2c_done during WR_GAP -> no state change; exec spacing remains exactly WR_GAP after the accepted done.
